code_sink_fifo: RTL
===================

// Module: code_sink_fifo
// PURPOSE
//  Downstream capture stage for the dual 64-bit generator (Output0/Output1 pair).
//  Each enabled cycle, samples the channel chosen by Slt and pushes {chan, data} into a FIFO.
//  A consumer drains the FIFO through a valid/ready handshake.
//  Overflow and occupancy are exposed for the bench and the top level.
// PARAMETERS
//  WIDTH   64  data width of each input channel and of Dout
//  DEPTH   8   FIFO entries; power of two, >=2
//  AW      3   pointer width, = log2(DEPTH)
// PORTS
//  Clk       in   1      clock; all state updates on rising edge
//  Reset     in   1      synchronous, active-high reset
//  En        in   1      sample request this cycle
//  Slt       in   1      channel select: 0 -> In0, 1 -> In1
//  In0       in   WIDTH  generator channel 0 (Output0)
//  In1       in   WIDTH  generator channel 1 (Output1)
//  Ready     in   1      consumer accepts the head entry this cycle
//  Valid     out  1      head entry present (= !Empty)
//  Dout      out  WIDTH  head entry data
//  DoutChan  out  1      head entry channel tag (Slt at push time)
//  Count     out  AW+1   entries held, 0..DEPTH
//  Full      out  1      Count == DEPTH
//  Empty     out  1      Count == 0
//  Overflow  out  1      sticky; a sample was dropped
// BEHAVIOUR
//  - Reset (sync): wr_ptr=rd_ptr=0, Count=0, Empty=1, Full=0, Valid=0, Overflow=0.
//    Dout=0 and DoutChan=0 while Empty. Storage contents are not cleared.
//  - push = En && (!Full || pop). Entry = {Slt, Slt ? In1 : In0}, sampled at the edge.
//  - pop = Valid && Ready. Head advances at the edge.
//    Dout/DoutChan are combinational reads of mem[rd_ptr], gated to 0 when Empty.
//  - Latency: a push at edge N is visible on Valid/Dout after edge N. There is no same-cycle bypass.
//  - Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Full && En && Ready: pop and push both happen; Count stays DEPTH; no drop.
//  - Full && En && !Ready: sample dropped; Overflow<=1 and holds until Reset.
//  - Empty && Ready: no pop; pointers unchanged.
//  - Pointers wrap modulo DEPTH. Full/Empty are derived from Count, not from pointer equality.
//  - Reset has priority over push/pop in the same cycle; an in-flight entry is discarded.
//  - En low: no push, whatever Slt/In0/In1 carry.
//  - No state machine beyond the FIFO. State is pointers, Count, Overflow, and the optional last-value register.
// CONFIGURATION
//  Macro CODE_SINK_DEDUP_EN:
//   - defined: keeps last_pushed {chan,data}, valid after the first push since Reset.
//     A push whose {Slt,data} equals last_pushed is suppressed: not stored, no Overflow.
//     Only accepted pushes update last_pushed. Reset invalidates it.
//   - undefined: every enabled, non-dropped cycle pushes; no last-value register exists.
// TESTING
//  1 Reset=1 two cycles -> Count=0, Empty=1, Valid=0, Dout=0, Overflow=0.
//  2 Ready=0; En=1 for 3 cycles with Slt=0, In0=5,8,13 -> Count=3; then Ready=1 -> Dout 5,8,13 in order, DoutChan=0.
//  3 Ready=0; En=1, Slt=1, In1=100..108 for 9 cycles (DEPTH=8) -> Full=1 after the 8th push,
//    9th dropped, Overflow=1; drain yields 100..107.
//  4 Full, Ready=1, En=1, In0=42, Slt=0 -> Count stays 8, head pops, 42 lands at tail, Overflow unchanged.
//  5 Wrap: 20 push/pop pairs with interleaved Slt -> data and channel order preserved; Count never exceeds DEPTH.
//  6 Reset=1 asserted with En=1, Count=5 -> next cycle Count=0, Overflow=0, Valid=0.
//    With CODE_SINK_DEDUP_EN: In0=7 held for 4 enabled cycles -> Count=1.

Source files
------------

// File: rtl/code_sink_fifo.sv
// Capture FIFO for the dual 64-bit generator: each enabled cycle pushes {Slt, selected channel}.
// Optional build macro CODE_SINK_DEDUP_EN suppresses pushes that repeat the last accepted entry.
module code_sink_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Slt,
   input  logic [WIDTH-1:0] In0,
   input  logic [WIDTH-1:0] In1,
   input  logic             Ready,
   output logic             Valid,
   output logic [WIDTH-1:0] Dout,
   output logic             DoutChan,
   output logic [AW:0]      Count,
   output logic             Full,
   output logic             Empty,
   output logic             Overflow
);

   localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH:0]  r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic            r_overflow;

   logic [WIDTH:0]  w_entry;
   logic [WIDTH:0]  w_head;
   logic            w_dup;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;

   // Handshake: the head entry transfers on a rising edge where Valid && Ready;
   // Valid never depends on Ready, and Dout/DoutChan are stable while Valid && !Ready.
   assign w_entry = {Slt, (Slt ? In1 : In0)};
   assign w_head  = r_mem[r_rd_ptr];

   assign Empty    = (r_count == '0);
   assign Full     = (r_count == L_FULL);
   assign Valid    = !Empty;
   assign Count    = r_count;
   assign Overflow = r_overflow;
   assign Dout     = Empty ? '0 : w_head[WIDTH-1:0];
   assign DoutChan = Empty ? 1'b0 : w_head[WIDTH];

`ifdef CODE_SINK_DEDUP_EN
   logic [WIDTH:0] r_last;
   logic           r_last_valid;

   assign w_dup = r_last_valid && (r_last == w_entry);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_last_valid <= 1'b0;
         r_last       <= '0;
      end else if (w_push) begin
         r_last_valid <= 1'b1;
         r_last       <= w_entry;
      end
   end
`else
   assign w_dup = 1'b0;
`endif

   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign w_pop  = Valid && Ready;
   assign w_push = En && !w_dup && (!Full || w_pop);
   assign w_drop = En && !w_dup && Full && !w_pop;

   always_ff @(posedge Clk) begin
      if (!Reset && w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop) r_overflow <= 1'b1;
      end
   end

endmodule
